// File: rtl/alu_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arb_if : one requester's operation handshake and response return path
// Rev 1.0
// ----------------------------------------------------------------------------
interface alu_arb_if;
  logic       valid;
  logic       ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic [2:0] shamt;
  logic       lock;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_z;

  modport master (
    output valid, a, b, op, shamt, lock,
    input  ready, rsp_valid, rsp_data, rsp_z
  );

  modport slave (
    input  valid, a, b, op, shamt, lock,
    output ready, rsp_valid, rsp_data, rsp_z
  );
endinterface
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_arb : round-robin arbiter with lock sharing one 8-bit ALU between two
//           requesters; results return one cycle after acceptance.
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_arb (
  input  logic       clk,
  input  logic       rst,
  alu_arb_if.slave   req0_if,
  alu_arb_if.slave   req1_if,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  output logic [2:0] alu_op_o,
  output logic [2:0] alu_shamt_o,
  input  logic [7:0] alu_out_i,
  input  logic [3:0] alu_flags_i
);
  // bit 1 set means no owner; otherwise bit 0 is the owning requester
  localparam logic [1:0] LOCK_NONE = 2'b10;

  logic       last_q, last_d;
  logic [1:0] lock_q, lock_d;
  logic       iss_v_q, iss_v_d;
  logic       iss_tag_q, iss_tag_d;
  logic [7:0] hold_a_q, hold_a_d;
  logic [7:0] hold_b_q, hold_b_d;
  logic [2:0] hold_op_q, hold_op_d;
  logic [2:0] hold_shamt_q, hold_shamt_d;

  logic       gnt_v;
  logic       gnt_idx;
  logic       owner_valid;
  logic [7:0] sel_a, sel_b;
  logic [2:0] sel_op, sel_shamt;
  logic       sel_lock;
  logic       unused_flags;

  assign unused_flags = ^alu_flags_i[2:0];

  // An owner that drops valid forfeits the lock in that same cycle.
  assign owner_valid = !lock_q[1] && (lock_q[0] ? req1_if.valid : req0_if.valid);

  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = 1'b0;
    if (!rst) begin
      if (owner_valid) begin
        gnt_v   = 1'b1;
        gnt_idx = lock_q[0];
      end else if (req0_if.valid && req1_if.valid) begin
        gnt_v   = 1'b1;
        gnt_idx = !last_q;
      end else if (req0_if.valid) begin
        gnt_v   = 1'b1;
        gnt_idx = 1'b0;
      end else if (req1_if.valid) begin
        gnt_v   = 1'b1;
        gnt_idx = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a     = gnt_idx ? req1_if.a     : req0_if.a;
    sel_b     = gnt_idx ? req1_if.b     : req0_if.b;
    sel_op    = gnt_idx ? req1_if.op    : req0_if.op;
    sel_shamt = gnt_idx ? req1_if.shamt : req0_if.shamt;
    sel_lock  = gnt_idx ? req1_if.lock  : req0_if.lock;

    last_d       = last_q;
    iss_tag_d    = iss_tag_q;
    iss_v_d      = gnt_v;
    lock_d       = LOCK_NONE;
    hold_a_d     = hold_a_q;
    hold_b_d     = hold_b_q;
    hold_op_d    = hold_op_q;
    hold_shamt_d = hold_shamt_q;

    if (gnt_v) begin
      last_d       = gnt_idx;
      iss_tag_d    = gnt_idx;
      lock_d       = sel_lock ? {1'b0, gnt_idx} : LOCK_NONE;
      hold_a_d     = sel_a;
      hold_b_d     = sel_b;
      hold_op_d    = sel_op;
      hold_shamt_d = sel_shamt;
    end
  end

  // Idle cycles replay the last accepted operation to keep the ALU inputs quiet.
  assign alu_a_o     = gnt_v ? sel_a     : hold_a_q;
  assign alu_b_o     = gnt_v ? sel_b     : hold_b_q;
  assign alu_op_o    = gnt_v ? sel_op    : hold_op_q;
  assign alu_shamt_o = gnt_v ? sel_shamt : hold_shamt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= 1'b1;
      lock_q       <= LOCK_NONE;
      iss_v_q      <= 1'b0;
      iss_tag_q    <= 1'b0;
      hold_a_q     <= 8'h00;
      hold_b_q     <= 8'h00;
      hold_op_q    <= 3'd0;
      hold_shamt_q <= 3'd0;
    end else begin
      last_q       <= last_d;
      lock_q       <= lock_d;
      iss_v_q      <= iss_v_d;
      iss_tag_q    <= iss_tag_d;
      hold_a_q     <= hold_a_d;
      hold_b_q     <= hold_b_d;
      hold_op_q    <= hold_op_d;
      hold_shamt_q <= hold_shamt_d;
    end
  end

  assign req0_if.ready     = gnt_v && !gnt_idx;
  assign req1_if.ready     = gnt_v &&  gnt_idx;
  assign req0_if.rsp_valid = iss_v_q && !iss_tag_q;
  assign req1_if.rsp_valid = iss_v_q &&  iss_tag_q;
  assign req0_if.rsp_data  = alu_out_i;
  assign req1_if.rsp_data  = alu_out_i;
  assign req0_if.rsp_z     = alu_flags_i[3];
  assign req1_if.rsp_z     = alu_flags_i[3];
endmodule
`default_nettype wire
